// File: rtl/doodle_pkg.sv
// Shared constants and types for the platform store and its scheduler.
// Optional build macro used by the scheduler: PLATFORM_RANDOM_X_EN.
package doodle_pkg;

    localparam int SCREEN_WIDTH  = 400;
    localparam int SCREEN_HEIGHT = 700;
    localparam int BLOCK_WIDTH   = 40;
    localparam int BLOCK_HEIGHT  = 5;
    localparam int SPAWN_GAP     = 35;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Platforms per horizontal row and rows per screen.
    localparam int COLS         = SCREEN_WIDTH / BLOCK_WIDTH;
    localparam int ROWS         = SCREEN_HEIGHT / BLOCK_HEIGHT;
    localparam int COUNT_BLOCKS = COLS * ROWS;
    localparam int IDX_W        = $clog2(COUNT_BLOCKS);
    localparam int COL_W        = $clog2(COLS);

    typedef logic [31:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EVAL,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Unsigned add clamped at the top of the coordinate range.
    function automatic coord_t sat_add(input coord_t a, input coord_t b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/platform_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used for random platform X placement.
// A nonzero seed keeps it out of the all-zero lock-up state.
module platform_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] value
);

    // Shift left, feeding back the XOR of the tap bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= SEED;
        end else if (en) begin
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
        end
    end

endmodule

// File: rtl/platform_respawn_scheduler.sv
// Scans every block slot once per view scroll, retiring active platforms that
// fell below the view floor and respawning them above the view top.
// Build option: define PLATFORM_RANDOM_X_EN for LFSR-driven X placement;
// the default build sweeps X deterministically across the columns.
module platform_respawn_scheduler
    import doodle_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             new_view,
    input  coord_t           min_y,
    output logic [IDX_W-1:0] rd_idx,
    input  coord_t           rd_y,
    input  logic             rd_active,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [IDX_W-1:0] wr_idx,
    output coord_t           wr_x,
    output coord_t           wr_y,
    output logic             wr_active,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT_BLOCKS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    coord_t           floor_y;
    coord_t           top_y;
    coord_t           pend_floor;
    coord_t           pend_top;
    logic             pending;
    coord_t           cursor;
    // Respawn count kept modulo the column count: only its residue is ever used.
    logic [COL_W-1:0] respawn_ctr;
    logic             hit;
    logic             last_slot;
    coord_t           spawn_y;
    logic [COL_W-1:0] x_col;

`ifdef PLATFORM_RANDOM_X_EN
    logic [15:0] lfsr;

    platform_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .value (lfsr)
    );

    assign x_col = COL_W'(lfsr % 16'(COLS));
`else
    assign x_col = respawn_ctr;
`endif

    assign rd_idx = idx;

    // Slot evaluation: respawn active platforms strictly below the floor.
    always_comb begin
        hit       = rd_active && (rd_y < floor_y);
        last_slot = (idx == LAST_IDX);
        spawn_y   = (cursor > top_y) ? cursor : top_y;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            ST_IDLE:  if (new_view) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_EVAL;
            ST_EVAL: begin
                if (hit)            state_next = ST_WRITE;
                else if (last_slot) state_next = ST_DONE;
                else                state_next = ST_FETCH;
            end
            ST_WRITE: begin
                if (wr_ready) state_next = last_slot ? ST_DONE : ST_FETCH;
            end
            ST_DONE:  state_next = (new_view || pending) ? ST_FETCH : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy     = (state == ST_FETCH) || (state == ST_EVAL) || (state == ST_WRITE);
        done     = (state == ST_DONE);
        wr_valid = (state == ST_WRITE);
    end

    // Scan datapath: slot index, view bounds, spawn cursor and write payload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            floor_y     <= '0;
            top_y       <= '0;
            pend_floor  <= '0;
            pend_top    <= '0;
            pending     <= 1'b0;
            cursor      <= coord_t'(SCREEN_HEIGHT);
            respawn_ctr <= '0;
            wr_idx      <= '0;
            wr_x        <= '0;
            wr_y        <= '0;
            wr_active   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (new_view) begin
                        floor_y <= min_y;
                        top_y   <= sat_add(min_y, coord_t'(SCREEN_HEIGHT));
                        idx     <= '0;
                    end
                end
                ST_EVAL: begin
                    if (hit) begin
                        wr_idx    <= idx;
                        wr_x      <= coord_t'(x_col) * coord_t'(BLOCK_WIDTH);
                        wr_y      <= spawn_y;
                        wr_active <= 1'b1;
                        cursor    <= sat_add(spawn_y, coord_t'(SPAWN_GAP));
                    end else if (!last_slot) begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        respawn_ctr <= (respawn_ctr == LAST_COL) ? '0 : respawn_ctr + 1'b1;
                        if (!last_slot) idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    // A pulse arriving exactly now is newer than anything pending.
                    if (new_view) begin
                        floor_y <= min_y;
                        top_y   <= sat_add(min_y, coord_t'(SCREEN_HEIGHT));
                        idx     <= '0;
                        pending <= 1'b0;
                    end else if (pending) begin
                        floor_y <= pend_floor;
                        top_y   <= pend_top;
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                default: ;
            endcase

            // A scroll during a scan is parked; the latest one wins.
            if (new_view && busy) begin
                pend_floor <= min_y;
                pend_top   <= sat_add(min_y, coord_t'(SCREEN_HEIGHT));
                pending    <= 1'b1;
            end
        end
    end

endmodule
